// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-organised data memory target with programmable wait states
// Accepts one access in IDLE, waits WAIT_CYCLES, then commits and answers with a one-cycle response.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        E
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [31:0] c_addr, c_wdata;
    logic        c_we, commit, fault;
    logic [IDX_W-1:0] idx;
    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the commit happens on the accepting edge, so it must use the live inputs.
    always_comb begin
        state_next = state;
        c_addr     = addr_q;
        c_wdata    = wdata_q;
        c_we       = we_q;
        case (state)
            IDLE: begin
                c_addr  = addr;
                c_wdata = wdata;
                c_we    = we;
                if (req) begin
                    if (WAIT_CYCLES == 0) state_next = RESP;
                    else                  state_next = WAIT;
                end
            end
            WAIT:    if (cnt == 4'd1) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        commit = (state_next == RESP) && (state != RESP);
        fault  = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= DEPTH_W);
        idx    = c_addr[IDX_W+1:2];
    end

    assign ready      = (state == IDLE);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            rdata   <= 32'd0;
            E       <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                we_q    <= we;
                cnt     <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                if (fault) begin
                    rdata <= 32'd0;
                    E     <= 1'b0;
                end else begin
                    rdata <= c_we ? 32'd0 : mem[idx];
                    E     <= 1'b1;
                end
            end
        end
    end

    // Storage is never reset; an aborted access never reaches its commit edge.
    always_ff @(posedge clk) begin
        if (commit && !Reset && !fault && c_we)
            mem[idx] <= c_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder at 2, 0 and 15 wait states
module tb_dmem_responder;
    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic [2:0]        req_v = '0, we_v = '0;
    logic [2:0]        ready_v, resp_v, e_v;
    logic [2:0][31:0]  addr_v = '0, wdata_v = '0;
    logic [2:0][31:0]  rdata_v;
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .Reset(Reset), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .ready(ready_v[0]), .resp_valid(resp_v[0]), .rdata(rdata_v[0]), .E(e_v[0]));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .Reset(Reset), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .ready(ready_v[1]), .resp_valid(resp_v[1]), .rdata(rdata_v[1]), .E(e_v[1]));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .Reset(Reset), .req(req_v[2]), .we(we_v[2]), .addr(addr_v[2]),
        .wdata(wdata_v[2]), .ready(ready_v[2]), .resp_valid(resp_v[2]), .rdata(rdata_v[2]), .E(e_v[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    // Issue one access on instance i from IDLE; lat counts edges from acceptance to the first resp_valid sample.
    task automatic access(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int lat);
        req_v[i] = 1'b1; we_v[i] = w; addr_v[i] = a; wdata_v[i] = d;
        tick();
        req_v[i] = 1'b0;
        lat = 1;
        while (!resp_v[i] && lat < 40) begin
            tick();
            lat++;
        end
        rd = rdata_v[i];
        e  = e_v[i];
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, ready_low, rv_at;
        logic [31:0] rd15;

        repeat (2) tick();
        chk("rst_ready", 32'(ready_v[0]), 32'd1);
        chk("rst_resp_valid", 32'(resp_v[0]), 32'd0);
        chk("rst_rdata", rdata_v[0], 32'd0);
        chk("rst_E", 32'(e_v[0]), 32'd0);
        chk("rst_ready_w15", 32'(ready_v[2]), 32'd1);
        Reset = 1'b0;

        access(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat);
        chk("wr10_latency", 32'(lat), 32'd3);
        chk("wr10_E", 32'(e), 32'd1);
        chk("wr10_rdata", rd, 32'd0);
        access(0, 1'b0, 32'h10, 32'd0, rd, e, lat);
        chk("rd10_rdata", rd, 32'hDEADBEEF);
        chk("rd10_E", 32'(e), 32'd1);
        chk("rd10_latency", 32'(lat), 32'd3);
        chk("rdata_hold", rdata_v[0], 32'hDEADBEEF);

        access(0, 1'b1, 32'h0, 32'h0A0B0C0D, rd, e, lat);
        access(0, 1'b0, 32'h13, 32'd0, rd, e, lat);
        chk("misaligned_E", 32'(e), 32'd0);
        chk("misaligned_rdata", rd, 32'd0);
        access(0, 1'b1, 32'h1000, 32'h1, rd, e, lat);
        chk("oob_write_E", 32'(e), 32'd0);
        access(0, 1'b0, 32'h0, 32'd0, rd, e, lat);
        chk("rd0_after_faults", rd, 32'h0A0B0C0D);
        chk("rd0_after_faults_E", 32'(e), 32'd1);

        access(0, 1'b1, 32'h44, 32'h33333333, rd, e, lat);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h40; wdata_v[0] = 32'h11111111;
        tick();
        chk("wait_ready_low", 32'(ready_v[0]), 32'd0);
        addr_v[0] = 32'h44; wdata_v[0] = 32'h22222222; we_v[0] = 1'b0; req_v[0] = 1'b1;
        tick();
        tick();
        chk("ign_resp_valid", 32'(resp_v[0]), 32'd1);
        chk("ign_E", 32'(e_v[0]), 32'd1);
        chk("ign_rdata", rdata_v[0], 32'd0);
        req_v[0] = 1'b0;
        tick();
        chk("ign_pulse_width", 32'(resp_v[0]), 32'd0);
        chk("ign_ready_back", 32'(ready_v[0]), 32'd1);
        tick();
        chk("ign_no_reaccept", 32'(ready_v[0]), 32'd1);
        access(0, 1'b0, 32'h40, 32'd0, rd, e, lat);
        chk("ign_rd40", rd, 32'h11111111);
        access(0, 1'b0, 32'h44, 32'd0, rd, e, lat);
        chk("ign_rd44", rd, 32'h33333333);

        req_v[1] = 1'b1; we_v[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr_v[1]  = 32'(4 * k);
            wdata_v[1] = 32'hC0DE0000 | 32'(k);
            tick();
            chk("b2b_resp_high", 32'(resp_v[1]), 32'd1);
            chk("b2b_E", 32'(e_v[1]), 32'd1);
            tick();
            chk("b2b_gap", 32'(resp_v[1]), 32'd0);
            chk("b2b_ready", 32'(ready_v[1]), 32'd1);
        end
        req_v[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            access(1, 1'b0, 32'(4 * k), 32'd0, rd, e, lat);
            chk("b2b_readback", rd, 32'hC0DE0000 | 32'(k));
            chk("b2b_rd_latency", 32'(lat), 32'd1);
        end

        access(0, 1'b1, 32'h20, 32'hCAFEF00D, rd, e, lat);
        access(0, 1'b0, 32'h20, 32'd0, rd, e, lat);
        chk("rd20_before", rd, 32'hCAFEF00D);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'h12345678;
        tick();
        req_v[0] = 1'b0;
        tick();
        #2 Reset = 1'b1;
        #1;
        chk("abort_ready", 32'(ready_v[0]), 32'd1);
        chk("abort_resp_valid", 32'(resp_v[0]), 32'd0);
        chk("abort_rdata", rdata_v[0], 32'd0);
        tick();
        chk("abort_no_pulse", 32'(resp_v[0]), 32'd0);
        Reset = 1'b0;
        chk("abort_E", 32'(e_v[0]), 32'd0);
        access(0, 1'b0, 32'h20, 32'd0, rd, e, lat);
        chk("rd20_after_abort", rd, 32'hCAFEF00D);
        chk("first_accept_after_reset", 32'(lat), 32'd3);

        access(2, 1'b1, 32'h8, 32'h5A5A5A5A, rd, e, lat);
        chk("w15_write_latency", 32'(lat), 32'd16);
        req_v[2] = 1'b1; we_v[2] = 1'b0; addr_v[2] = 32'h8;
        tick();
        req_v[2] = 1'b0;
        ready_low = 0; rv_at = 0; rd15 = 32'd0;
        for (int c = 1; c <= 20; c++) begin
            if (!ready_v[2]) ready_low++;
            if (resp_v[2] && rv_at == 0) begin
                rv_at = c;
                rd15 = rdata_v[2];
            end
            tick();
        end
        chk("w15_ready_low_cycles", 32'(ready_low), 32'd16);
        chk("w15_resp_at", 32'(rv_at), 32'd16);
        chk("w15_rdata", rd15, 32'h5A5A5A5A);
        chk("w15_ready_after", 32'(ready_v[2]), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
